// File: rtl/keypad_alarm_ctrl.sv
// Matrix keypad scanner with debounce, passcode entry, arm/disarm toggle,
// wrong-code lockout, partial-entry timeout and sticky breach alert.
module keypad_alarm_ctrl #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int CODE_LEN     = 4,
  parameter int DEBOUNCE_CYC = 4,
  parameter int MAX_FAILS    = 3,
  parameter int LOCKOUT_CYC  = 64,
  parameter int TIMEOUT_CYC  = 256,
  localparam int KW = $clog2(ROWS*COLS),
  localparam int FW = $clog2(MAX_FAILS+1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ROWS-1:0]        row,
  input  logic [CODE_LEN*KW-1:0] code,
  input  logic                   breach,
  output logic [COLS-1:0]        col,
  output logic                   key_valid,
  output logic [KW-1:0]          key_code,
  output logic                   armed,
  output logic                   alert,
  output logic                   locked,
  output logic [FW-1:0]          fail_cnt
);
  localparam int CW  = $clog2(COLS);
  localparam int DBW = $clog2(DEBOUNCE_CYC+1);
  localparam int PW  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int LW  = $clog2(LOCKOUT_CYC+1);
  localparam int TW  = $clog2(TIMEOUT_CYC+1);

  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} scan_state_t;

  scan_state_t     state_reg, state_next;
  logic [CW-1:0]   col_idx_reg, col_idx_next, col_adv;
  logic [ROWS-1:0] latch_reg, latch_next;
  logic [DBW-1:0]  db_cnt_reg, db_cnt_next;
  logic [KW-1:0]   key_code_reg, cur_key;
  int              row_sel;

  logic [PW-1:0]   pos_reg, pos_next;
  logic            mism_reg, mism_next;
  logic            armed_reg, armed_next;
  logic            alert_reg, alert_next;
  logic            locked_reg, locked_next;
  logic [FW-1:0]   fail_reg, fail_next;
  logic [LW-1:0]   lock_cnt_reg, lock_cnt_next;
  logic [TW-1:0]   tout_reg, tout_next;
  logic            accept, digit_bad, last_digit;

  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    assign col[gi] = (col_idx_reg == CW'(gi));
  end

  assign col_adv = (col_idx_reg == CW'(COLS-1)) ? '0 : col_idx_reg + 1'b1;

  // Lowest pressed row wins when several rows are active in the frozen column.
  always_comb begin
    row_sel = 0;
    for (int i = ROWS-1; i >= 0; i--)
      if (latch_reg[i]) row_sel = i;
    cur_key = KW'(row_sel * COLS + int'(col_idx_reg));
  end

  always_comb begin
    state_next   = state_reg;
    col_idx_next = col_idx_reg;
    latch_next   = latch_reg;
    db_cnt_next  = db_cnt_reg;
    key_valid    = 1'b0;
    unique case (state_reg)
      SCAN: begin
        if (row != '0) begin
          latch_next  = row;
          db_cnt_next = DBW'(1);
          state_next  = PRESS_DB;
        end else begin
          col_idx_next = col_adv;
        end
      end
      PRESS_DB: begin
        if (db_cnt_reg == DBW'(DEBOUNCE_CYC)) begin
          key_valid  = 1'b1;
          state_next = HELD;
        end else if (row == '0) begin
          state_next   = SCAN;
          col_idx_next = col_adv;
        end else if (row == latch_reg) begin
          db_cnt_next = db_cnt_reg + 1'b1;
        end else begin
          latch_next  = row;
          db_cnt_next = DBW'(1);
        end
      end
      HELD: begin
        if (row == '0) begin
          db_cnt_next = DBW'(1);
          state_next  = REL_DB;
        end
      end
      REL_DB: begin
        // The zero seen in HELD is the first of the required quiet samples.
        if (row != '0) begin
          state_next = HELD;
        end else if (db_cnt_reg >= DBW'(DEBOUNCE_CYC-1)) begin
          state_next   = SCAN;
          col_idx_next = col_adv;
        end else begin
          db_cnt_next = db_cnt_reg + 1'b1;
        end
      end
      default: state_next = SCAN;
    endcase
  end

  assign key_code = key_valid ? cur_key : key_code_reg;

  assign accept     = key_valid && !locked_reg;
  assign digit_bad  = (cur_key != code[int'(pos_reg)*KW +: KW]);
  assign last_digit = (pos_reg == PW'(CODE_LEN-1));

  always_comb begin
    pos_next      = pos_reg;
    mism_next     = mism_reg;
    armed_next    = armed_reg;
    alert_next    = alert_reg;
    locked_next   = locked_reg;
    fail_next     = fail_reg;
    lock_cnt_next = lock_cnt_reg;
    tout_next     = tout_reg;

    if (breach && armed_reg) alert_next = 1'b1;

    if (locked_reg) begin
      if (lock_cnt_reg <= LW'(1)) begin
        locked_next   = 1'b0;
        lock_cnt_next = '0;
      end else begin
        lock_cnt_next = lock_cnt_reg - 1'b1;
      end
    end

    // A key arriving on the expiry cycle counts as a digit, so it is checked first.
    if (key_valid) begin
      tout_next = '0;
      if (accept) begin
        if (last_digit) begin
          pos_next  = '0;
          mism_next = 1'b0;
          if (!(mism_reg || digit_bad)) begin
            armed_next = !armed_reg;
            fail_next  = '0;
            alert_next = 1'b0;
          end else if (fail_reg == FW'(MAX_FAILS-1)) begin
            locked_next   = 1'b1;
            lock_cnt_next = LW'(LOCKOUT_CYC);
            fail_next     = '0;
            if (armed_reg) alert_next = 1'b1;
          end else begin
            fail_next = fail_reg + 1'b1;
          end
        end else begin
          pos_next  = pos_reg + 1'b1;
          mism_next = mism_reg || digit_bad;
        end
      end
    end else if (pos_reg != '0) begin
      if (tout_reg == TW'(TIMEOUT_CYC-1)) begin
        pos_next  = '0;
        mism_next = 1'b0;
        tout_next = '0;
      end else begin
        tout_next = tout_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= SCAN;
      col_idx_reg  <= '0;
      latch_reg    <= '0;
      db_cnt_reg   <= '0;
      key_code_reg <= '0;
      pos_reg      <= '0;
      mism_reg     <= 1'b0;
      armed_reg    <= 1'b0;
      alert_reg    <= 1'b0;
      locked_reg   <= 1'b0;
      fail_reg     <= '0;
      lock_cnt_reg <= '0;
      tout_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      col_idx_reg  <= col_idx_next;
      latch_reg    <= latch_next;
      db_cnt_reg   <= db_cnt_next;
      if (key_valid) key_code_reg <= cur_key;
      pos_reg      <= pos_next;
      mism_reg     <= mism_next;
      armed_reg    <= armed_next;
      alert_reg    <= alert_next;
      locked_reg   <= locked_next;
      fail_reg     <= fail_next;
      lock_cnt_reg <= lock_cnt_next;
      tout_reg     <= tout_next;
    end
  end

  assign armed    = armed_reg;
  assign alert    = alert_reg;
  assign locked   = locked_reg;
  assign fail_cnt = fail_reg;

endmodule
